// File: rtl/processor_pkg.sv
//------------------------------------------------------------------------------
// Module      : processor_pkg
// Description : Shared widths, ALU opcodes and CCR bit positions for the core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package processor_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int ALUOP_W    = 3;

    localparam logic [ALUOP_W-1:0] ALU_MOV = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_INC = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_DEC = 3'b111;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

endpackage

`default_nettype wire

// File: rtl/alu_unit.sv
//------------------------------------------------------------------------------
// Module      : alu_unit
// Description : Combinational ALU producing the result, Z/N/C and write enables.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_unit
    import processor_pkg::*;
#(
    parameter int DATA_W  = processor_pkg::DATA_W,
    parameter int ALUOP_W = processor_pkg::ALUOP_W
) (
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [ALUOP_W-1:0] op,
    output logic [DATA_W-1:0]  result,
    output logic               z,
    output logic               n,
    output logic               c,
    output logic               c_we,
    output logic               flags_we
);

    localparam logic [DATA_W-1:0] c_one  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] c_zero = '0;

    // One extra bit so the carry out of ADD/INC falls out of the sum directly.
    logic [DATA_W:0] w_wide;

    always_comb begin
        w_wide   = '0;
        result   = '0;
        c        = 1'b0;
        c_we     = 1'b0;
        flags_we = 1'b1;
        case (op)
            ALU_MOV: begin
                result   = b;
                flags_we = 1'b0;
            end
            ALU_ADD: begin
                w_wide = {1'b0, a} + {1'b0, b};
                result = w_wide[DATA_W-1:0];
                c      = w_wide[DATA_W];
                c_we   = 1'b1;
            end
            ALU_SUB: begin
                result = a - b;
                c      = (a < b);
                c_we   = 1'b1;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOT: result = ~a;
            ALU_INC: begin
                w_wide = {1'b0, a} + {1'b0, c_one};
                result = w_wide[DATA_W-1:0];
                c      = w_wide[DATA_W];
                c_we   = 1'b1;
            end
            ALU_DEC: begin
                result = a - c_one;
                c      = (a == c_zero);
                c_we   = 1'b1;
            end
            default: begin
                result   = b;
                flags_we = 1'b0;
            end
        endcase
        z = (result == c_zero);
        n = result[DATA_W-1];
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
//------------------------------------------------------------------------------
// Module      : ex_stage
// Description : Execute stage: operand select, ALU, CCR and EX/MEM register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage
    import processor_pkg::*;
#(
    parameter int DATA_W     = processor_pkg::DATA_W,
    parameter int REG_ADDR_W = processor_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = processor_pkg::ALUOP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     op1,
    input  logic [DATA_W-1:0]     R_op2,
    input  logic [DATA_W-1:0]     I_op2,
    input  logic [REG_ADDR_W-1:0] write_addr,
    input  logic [ALUOP_W-1:0]    aluOp,
    input  logic                  RegWR,
    input  logic                  aluSrc,
    input  logic                  MemWR,
    input  logic                  MemR,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     store_data,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_RegWR,
    output logic                  wb_MemWR,
    output logic                  wb_MemR,
    output logic                  valid_out,
    output logic [2:0]            ccr
);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_result;
    logic              w_z;
    logic              w_n;
    logic              w_c;
    logic              w_c_we;
    logic              w_flags_we;

    logic [DATA_W-1:0]     r_alu_result;
    logic [DATA_W-1:0]     r_store_data;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic                  r_wb_regwr;
    logic                  r_wb_memwr;
    logic                  r_wb_memr;
    logic                  r_valid;
    logic [2:0]            r_ccr;

    assign w_b = aluSrc ? I_op2 : R_op2;

    alu_unit #(
        .DATA_W  (DATA_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu (
        .a        (op1),
        .b        (w_b),
        .op       (aluOp),
        .result   (w_result),
        .z        (w_z),
        .n        (w_n),
        .c        (w_c),
        .c_we     (w_c_we),
        .flags_we (w_flags_we)
    );

    // rst > flush > stall > normal; a bubble clears the payload but keeps ccr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_wb_addr    <= '0;
            r_wb_regwr   <= 1'b0;
            r_wb_memwr   <= 1'b0;
            r_wb_memr    <= 1'b0;
            r_valid      <= 1'b0;
            r_ccr        <= 3'b000;
        end else if (flush) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_wb_addr    <= '0;
            r_wb_regwr   <= 1'b0;
            r_wb_memwr   <= 1'b0;
            r_wb_memr    <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!stall) begin
            r_alu_result <= w_result;
            r_store_data <= R_op2;
            r_wb_addr    <= write_addr;
            r_wb_regwr   <= RegWR;
            r_wb_memwr   <= MemWR;
            r_wb_memr    <= MemR;
            r_valid      <= 1'b1;
            if (w_flags_we) begin
                r_ccr[CCR_Z] <= w_z;
                r_ccr[CCR_N] <= w_n;
            end
            if (w_c_we) begin
                r_ccr[CCR_C] <= w_c;
            end
        end
    end

    assign alu_result = r_alu_result;
    assign store_data = r_store_data;
    assign wb_addr    = r_wb_addr;
    assign wb_RegWR   = r_wb_regwr;
    assign wb_MemWR   = r_wb_memwr;
    assign wb_MemR    = r_wb_memr;
    assign valid_out  = r_valid;
    assign ccr        = r_ccr;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_ex_stage
// Description : Directed self-checking bench for ex_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] op1;
    logic [15:0] R_op2;
    logic [15:0] I_op2;
    logic [2:0]  write_addr;
    logic [2:0]  aluOp;
    logic        RegWR;
    logic        aluSrc;
    logic        MemWR;
    logic        MemR;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [2:0]  wb_addr;
    logic        wb_RegWR;
    logic        wb_MemWR;
    logic        wb_MemR;
    logic        valid_out;
    logic [2:0]  ccr;

    int n_checks;
    int n_errors;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .op1        (op1),
        .R_op2      (R_op2),
        .I_op2      (I_op2),
        .write_addr (write_addr),
        .aluOp      (aluOp),
        .RegWR      (RegWR),
        .aluSrc     (aluSrc),
        .MemWR      (MemWR),
        .MemR       (MemR),
        .alu_result (alu_result),
        .store_data (store_data),
        .wb_addr    (wb_addr),
        .wb_RegWR   (wb_RegWR),
        .wb_MemWR   (wb_MemWR),
        .wb_MemR    (wb_MemR),
        .valid_out  (valid_out),
        .ccr        (ccr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] r,
                         input logic [15:0] imm, input logic src, input logic [2:0] wa,
                         input logic rw, input logic mw, input logic mr);
        aluOp = op; op1 = a; R_op2 = r; I_op2 = imm; aluSrc = src;
        write_addr = wa; RegWR = rw; MemWR = mw; MemR = mr;
    endtask

    task automatic check_all(input string tag, input logic [15:0] res, input logic [15:0] sd,
                             input logic [2:0] wa, input logic rw, input logic mw,
                             input logic mr, input logic v, input logic [2:0] cc);
        check({tag, ".alu_result"}, {16'h0, alu_result}, {16'h0, res});
        check({tag, ".store_data"}, {16'h0, store_data}, {16'h0, sd});
        check({tag, ".wb_addr"},    {29'h0, wb_addr},    {29'h0, wa});
        check({tag, ".wb_RegWR"},   {31'h0, wb_RegWR},   {31'h0, rw});
        check({tag, ".wb_MemWR"},   {31'h0, wb_MemWR},   {31'h0, mw});
        check({tag, ".wb_MemR"},    {31'h0, wb_MemR},    {31'h0, mr});
        check({tag, ".valid_out"},  {31'h0, valid_out},  {31'h0, v});
        check({tag, ".ccr"},        {29'h0, ccr},        {29'h0, cc});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        stall = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;

        // Reset held two cycles with random live inputs
        for (int i = 0; i < 2; i++) begin
            drive(3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  3'($urandom), 1'b1, 1'b1, 1'b1);
            tick();
            check_all("reset", 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 0, 3'b000);
        end

        // ADD with carry out to zero
        rst = 1'b0;
        drive(3'b001, 16'hFFFF, 16'h0001, 16'h7777, 1'b0, 3'd5, 1, 0, 0);
        tick();
        check_all("add_carry", 16'h0000, 16'h0001, 3'd5, 1, 0, 0, 1, 3'b101);

        // AND keeps C
        drive(3'b011, 16'h00F0, 16'h0F00, 16'h0000, 1'b0, 3'd2, 1, 0, 0);
        tick();
        check_all("and_keepc", 16'h0000, 16'h0F00, 3'd2, 1, 0, 0, 1, 3'b101);

        // MOV leaves all flags alone
        drive(3'b000, 16'h1111, 16'h8000, 16'h0000, 1'b0, 3'd3, 1, 0, 1);
        tick();
        check_all("mov", 16'h8000, 16'h8000, 3'd3, 1, 0, 1, 1, 3'b101);

        // SUB with immediate and borrow; store_data still carries R_op2
        drive(3'b010, 16'h0003, 16'h1234, 16'h0005, 1'b1, 3'd1, 1, 0, 0);
        tick();
        check_all("sub_imm", 16'hFFFE, 16'h1234, 3'd1, 1, 0, 0, 1, 3'b110);

        // SUB 9-2 then stall three cycles with different inputs
        drive(3'b010, 16'h0009, 16'h0002, 16'h0000, 1'b0, 3'd4, 1, 0, 0);
        tick();
        check_all("sub_plain", 16'h0007, 16'h0002, 3'd4, 1, 0, 0, 1, 3'b000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'd6, 0, 1, 0);
            tick();
            check_all("stall", 16'h0007, 16'h0002, 3'd4, 1, 0, 0, 1, 3'b000);
        end

        // Release: NOT 0000 -> FFFF, N set, C held at 0
        stall = 1'b0;
        drive(3'b101, 16'h0000, 16'h00AA, 16'h0000, 1'b0, 3'd7, 1, 0, 0);
        tick();
        check_all("not", 16'hFFFF, 16'h00AA, 3'd7, 1, 0, 0, 1, 3'b010);

        // INC wraps FFFF -> 0000 with carry
        drive(3'b110, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 3'd2, 1, 0, 0);
        tick();
        check_all("inc_wrap", 16'h0000, 16'h0000, 3'd2, 1, 0, 0, 1, 3'b101);

        // DEC wraps 0000 -> FFFF with borrow
        drive(3'b111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd3, 1, 0, 0);
        tick();
        check_all("dec_wrap", 16'hFFFF, 16'h0000, 3'd3, 1, 0, 0, 1, 3'b110);

        // OR with immediate, C held
        drive(3'b100, 16'h00F0, 16'h5555, 16'h0F0F, 1'b1, 3'd6, 1, 0, 0);
        tick();
        check_all("or_imm", 16'h0FFF, 16'h5555, 3'd6, 1, 0, 0, 1, 3'b100);

        // Flush together with stall on a store: bubble, ccr held
        flush = 1'b1;
        stall = 1'b1;
        drive(3'b001, 16'h0001, 16'h0001, 16'h0000, 1'b0, 3'd5, 0, 1, 0);
        tick();
        check_all("flush_stall", 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 0, 3'b100);

        // Normal store after the bubble
        flush = 1'b0;
        stall = 1'b0;
        drive(3'b001, 16'h0010, 16'hBEEF, 16'h0020, 1'b1, 3'd1, 0, 1, 0);
        tick();
        check_all("store", 16'h0030, 16'hBEEF, 3'd1, 0, 1, 0, 1, 3'b000);

        // Reset alongside flush and stall
        rst   = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        drive(3'b110, 16'h7FFF, 16'h1111, 16'h0000, 1'b0, 3'd7, 1, 1, 1);
        tick();
        check_all("rst_flush", 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 0, 3'b000);

        // Leaving reset: first instruction appears after one edge
        rst   = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        drive(3'b110, 16'h7FFF, 16'h1111, 16'h0000, 1'b0, 3'd7, 1, 0, 1);
        tick();
        check_all("post_rst", 16'h8000, 16'h1111, 3'd7, 1, 0, 1, 1, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage, directly downstream of the decode stage.
- Consumes decode outputs (op1, R_op2, I_op2, write_addr, aluOp and control bits) and selects the second operand.
- Performs the ALU operation and updates the condition code register (CCR).
- Registers the result and the surviving control into the EX/MEM pipeline register feeding the memory stage.

Parameters:
- DATA_W, 16, operand/result width
- REG_ADDR_W, 3, register-file address width
- ALUOP_W, 3, ALU opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage state this cycle
- flush  in  1  insert a bubble instead of the current instruction
- op1  in  DATA_W  first operand (Rsrc1)
- R_op2  in  DATA_W  register second operand
- I_op2  in  DATA_W  immediate second operand, already extended by decode
- write_addr  in  REG_ADDR_W  destination register
- aluOp  in  ALUOP_W  ALU operation code
- RegWR  in  1  register write enable
- aluSrc  in  1  0 = R_op2, 1 = I_op2
- MemWR  in  1  memory write
- MemR  in  1  memory read
- alu_result  out  DATA_W  registered ALU result (memory address for loads/stores)
- store_data  out  DATA_W  registered R_op2 (data for stores)
- wb_addr  out  REG_ADDR_W  registered write_addr
- wb_RegWR  out  1  registered RegWR
- wb_MemWR  out  1  registered MemWR
- wb_MemR  out  1  registered MemR
- valid_out  out  1  EX/MEM holds a real (non-bubble) instruction
- ccr  out  3  {C,N,Z}, bit0 = Z, bit1 = N, bit2 = C

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high on clk; port names are clk and rst.
  - Priority per edge: rst > flush > stall > normal.
- Reset values: every output is 0, and ccr is 3'b000.
- Operand select: B = aluSrc ? I_op2 : R_op2 (combinational).
- ALU operations (combinational, DATA_W bits, unsigned wrap):
  - 000 MOV: B; flags unchanged
  - 001 ADD: op1 + B; C = carry out
  - 010 SUB: op1 - B; C = 1 when op1 < B (borrow)
  - 011 AND: op1 & B; C unchanged
  - 100 OR: op1 | B; C unchanged
  - 101 NOT: ~op1; C unchanged
  - 110 INC: op1 + 1; C = carry out
  - 111 DEC: op1 - 1; C = 1 when op1 == 0
- Flags, for every op except MOV: Z = (result == 0), N = result[DATA_W-1].
- CCR write:
  - Updated at the edge on which the instruction is latched (not stalled, not flushed).
  - A flushed or stalled cycle never changes ccr.
- Latency:
  - One cycle: inputs present before edge N appear on the outputs after edge N.
  - ccr changes at the same edge.
- Normal edge:
  - alu_result <= result; store_data <= R_op2; wb_addr <= write_addr.
  - wb_RegWR/MemWR/MemR <= inputs; valid_out <= 1.
- Stall edge: all outputs and ccr hold their values.
- Flush edge:
  - wb_RegWR = wb_MemWR = wb_MemR = 0 and valid_out = 0.
  - alu_result, store_data and wb_addr are cleared to 0; ccr holds.
  - Flush wins over a simultaneous stall.
- Reset during a stall or flush: reset wins, and every output returns to 0 at that edge.
- Arithmetic overflow wraps modulo 2^DATA_W; there is no overflow flag.

Decomposition:
- Shared package processor_pkg:
  - Constants DATA_W and REG_ADDR_W.
  - ALU opcode localparams ALU_MOV..ALU_DEC.
  - CCR bit indices CCR_Z = 0, CCR_N = 1, CCR_C = 2.
- Sub-module alu_unit (purely combinational):
  - Inputs: a, b, op.
  - Outputs: result, z, n, c, c_we, flags_we.
- ex_stage holds the operand mux, the EX/MEM register, the CCR and the priority logic.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, ccr = 000; deassert -> first instruction appears one edge later.
- ADD carry: op1 = FFFF, R_op2 = 0001, aluSrc = 0, aluOp = 001, RegWR = 1, write_addr = 5 -> alu_result = 0000, ccr = 101 (C = 1, Z = 1), wb_addr = 5, wb_RegWR = 1, valid_out = 1.
- SUB borrow with immediate: op1 = 0003, I_op2 = 0005, aluSrc = 1, aluOp = 010 -> alu_result = FFFE, ccr = 110 (C = 1, N = 1, Z = 0).
- Flag retention:
  - After the ADD above (ccr = 101), issue AND op1 = 00F0, B = 0F00 -> result 0000, ccr = 101 (C kept).
  - Then MOV B = 8000 -> alu_result = 8000, ccr still 101.
- Stall: latch SUB 0009 - 0002 (result 0007, ccr = 000), then assert stall for 3 cycles with new inputs -> outputs and ccr frozen at 0007/000; release -> next instruction appears after one edge.
- Flush with stall:
  - Assert flush and stall together with a store (MemWR = 1, aluOp = 001) -> valid_out = 0, wb_MemWR = 0, alu_result = 0, ccr unchanged.
  - Rst asserted alongside flush -> all outputs 0.
